// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic trigger generator and echo timer.
// Converts round-trip time straight into a 3-digit BCD distance.
module echo_ranger #(
  parameter int CYCLES_PER_CM = 5882,
  parameter int TRIG_CYCLES   = 1000,
  parameter int PERIOD_CYCLES = 3000000,
  parameter int MAX_CM        = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sig_in,
  output logic        sig_mod,
  output logic [11:0] dist_bcd,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam logic [11:0] MAX_BCD = 12'(
    ((MAX_CM / 100) % 10) * 256 +
    ((MAX_CM / 10) % 10) * 16 +
    (MAX_CM % 10));

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [SW-1:0] sub;
  logic [PW-1:0] per;
  logic [11:0]   bcd;
  logic [11:0]   bcd_next;
  logic          wrap;
  logic          hit_max;
  logic          enter_trig;
  logic          pend;

  logic s1, s2, s3;
  logic g1, g2;
  logic echo_rise;

  assign wrap = (sub == SW'(CYCLES_PER_CM - 1));
  assign hit_max = wrap && (bcd_next == MAX_BCD);
  assign enter_trig = (state == IDLE) ||
    ((state == HOLD) && (per == PW'(PERIOD_CYCLES - 1)));

  // Synchronize echo, detect rising edge; edges that began while the
  // trigger was high are masked by carrying sig_mod alongside the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      g1 <= 1'b0;
      g2 <= 1'b0;
      echo_rise <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      g1 <= sig_mod;
      g2 <= g1;
      echo_rise <= s2 & ~s3 & ~g2;
    end
  end

  // Decimal increment of the BCD range count.
  always_comb begin
    bcd_next = bcd;
    if (bcd[3:0] == 4'd9) begin
      bcd_next[3:0] = 4'd0;
      if (bcd[7:4] == 4'd9) begin
        bcd_next[7:4] = 4'd0;
        bcd_next[11:8] = bcd[11:8] + 4'd1;
      end else begin
        bcd_next[7:4] = bcd[7:4] + 4'd1;
      end
    end else begin
      bcd_next[3:0] = bcd[3:0] + 4'd1;
    end
  end

  // Period counter: cleared on each trigger start.
  always_ff @(posedge clk) begin
    if (reset || enter_trig) begin
      per <= '0;
    end else begin
      per <= per + PW'(1);
    end
  end

  // Range timer: sub-counter per centimetre plus BCD count.
  always_ff @(posedge clk) begin
    if (reset || enter_trig) begin
      sub <= '0;
      bcd <= '0;
    end else if (state == TRIG || state == WAIT) begin
      sub <= wrap ? '0 : sub + SW'(1);
      if (wrap) begin
        bcd <= bcd_next;
      end
    end
  end

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sig_mod    <= 1'b0;
      dist_bcd   <= 12'h000;
      timeout    <= 1'b0;
      dist_valid <= 1'b0;
      pend       <= 1'b0;
    end else begin
      dist_valid <= pend;
      pend       <= 1'b0;
      case (state)
        IDLE: begin
          state   <= TRIG;
          sig_mod <= 1'b1;
        end
        TRIG: begin
          if (per == PW'(TRIG_CYCLES - 1)) begin
            state   <= WAIT;
            sig_mod <= 1'b0;
          end
        end
        WAIT: begin
          if (echo_rise) begin
            dist_bcd <= bcd;
            timeout  <= 1'b0;
            pend     <= 1'b1;
            state    <= HOLD;
          end else if (hit_max) begin
            dist_bcd <= 12'h999;
            timeout  <= 1'b1;
            pend     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (per == PW'(PERIOD_CYCLES - 1)) begin
            state   <= TRIG;
            sig_mod <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          sig_mod <= 1'b0;
        end
      endcase
    end
  end

endmodule
